// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
// Holds the scan FSM state encoding and the default parameter values
// used by seg7_scan_ctrl.
package seg7_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2,
        OFF   = 2'd3
    } scan_state_t;

    localparam int DIGITS_DEF       = 4;
    localparam int BLANK_CYCLES_DEF = 2;

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Hex nibble to seven-segment decoder.
// Ports:
//   nibble   - 4-bit hex digit to display
//   polarity - 1 = segments active-high, 0 = active-low
//   seg      - segment pattern, bit order 6..0 = g..a
module decode_7seg_hex (
    input  logic [3:0] nibble,
    input  logic       polarity,
    output logic [6:0] seg
);

    logic [6:0] raw;

    always_comb begin
        raw = 7'h00;
        case (nibble)
            4'h0: raw = 7'h3F;
            4'h1: raw = 7'h06;
            4'h2: raw = 7'h5B;
            4'h3: raw = 7'h4F;
            4'h4: raw = 7'h66;
            4'h5: raw = 7'h6D;
            4'h6: raw = 7'h7D;
            4'h7: raw = 7'h07;
            4'h8: raw = 7'h7F;
            4'h9: raw = 7'h6F;
            4'hA: raw = 7'h77;
            4'hB: raw = 7'h7C;
            4'hC: raw = 7'h39;
            4'hD: raw = 7'h5E;
            4'hE: raw = 7'h79;
            4'hF: raw = 7'h71;
            default: raw = 7'h00;
        endcase
    end

    assign seg = polarity ? raw : ~raw;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display scan controller.
// Each digit gets one slot: a dark BLANK phase (anti-ghosting), an ON phase
// whose length sets brightness, then an OFF phase padding the slot to a
// fixed length of BLANK_CYCLES + 16*(prescale+1) cycles.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   enable      - 1 = scan, 0 = dark and idle
//   value       - hex value, nibble n drives digit n
//   prescale    - sub-period length minus 1 (sampled per slot)
//   brightness  - on-time in sixteenths minus 1 (sampled per slot)
//   lz_blank    - suppress leading zero digits
//   seg_pol     - segment polarity (1 = active-high)
//   dig_pol     - digit-select polarity (1 = active-high)
//   seg_out     - shared segment lines g..a
//   dig_out     - one-hot digit selects
//   cur_digit   - index of the slot in progress
//   frame_done  - one-cycle pulse in the last cycle of the last slot
module seg7_scan_ctrl
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEF,
    parameter int PRESCALE_W   = 16,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            brightness,
    input  logic                  lz_blank,
    input  logic                  seg_pol,
    input  logic                  dig_pol,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_out,
    output logic [1:0]            cur_digit,
    output logic                  frame_done
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [1:0]    LAST_DIGIT = 2'(DIGITS - 1);

    scan_state_t           state_reg, state_next;
    logic [1:0]            digit_reg, digit_next;
    logic [4*DIGITS-1:0]   snap_reg, snap_next;
    logic [PRESCALE_W-1:0] pre_reg, pre_next;
    logic [3:0]            bright_reg, bright_next;
    logic [BW-1:0]         bcnt_reg, bcnt_next;
    logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
    logic [3:0]            tick_reg, tick_next;
    logic [6:0]            seg_reg, seg_next;
    logic [DIGITS-1:0]     dig_reg, dig_next;

    logic                  slot_end;
    logic                  start_slot;
    logic                  sub_end;
    logic [3:0]            nib [4];
    logic [3:0]            lz_mask;
    logic [3:0]            nib_sel;
    logic [6:0]            dec_seg;
    logic [3:0]            onehot;

    // Per-digit nibble and leading-zero flag, padded to four entries so the
    // 2-bit digit index never selects outside the vectors.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            if (gi < DIGITS) begin : g_used
                assign nib[gi] = snap_reg[4*gi +: 4];
                if (gi == 0) begin : g_lsd
                    assign lz_mask[gi] = 1'b0;
                end else begin : g_upper
                    assign lz_mask[gi] = lz_blank &&
                        (snap_reg[4*DIGITS-1:4*gi] == '0);
                end
            end else begin : g_unused
                assign nib[gi]     = 4'h0;
                assign lz_mask[gi] = 1'b0;
            end
        end
    endgenerate

    assign nib_sel = nib[digit_reg];
    assign onehot  = 4'd1 << digit_reg;
    assign sub_end = (pcnt_reg == pre_reg);

    decode_7seg_hex u_decode (
        .nibble   (nib_sel),
        .polarity (1'b1),
        .seg      (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            digit_reg  <= 2'd0;
            snap_reg   <= '0;
            pre_reg    <= '0;
            bright_reg <= 4'd0;
            bcnt_reg   <= '0;
            pcnt_reg   <= '0;
            tick_reg   <= 4'd0;
            seg_reg    <= 7'd0;
            dig_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            digit_reg  <= digit_next;
            snap_reg   <= snap_next;
            pre_reg    <= pre_next;
            bright_reg <= bright_next;
            bcnt_reg   <= bcnt_next;
            pcnt_reg   <= pcnt_next;
            tick_reg   <= tick_next;
            seg_reg    <= seg_next;
            dig_reg    <= dig_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        digit_next  = digit_reg;
        snap_next   = snap_reg;
        pre_next    = pre_reg;
        bright_next = bright_reg;
        bcnt_next   = bcnt_reg;
        pcnt_next   = pcnt_reg;
        tick_next   = tick_reg;
        seg_next    = 7'd0;
        dig_next    = '0;
        frame_done  = 1'b0;
        slot_end    = 1'b0;
        start_slot  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    start_slot = 1'b1;
                    digit_next = 2'd0;
                end
            end
            BLANK: begin
                if (bcnt_reg == BLANK_LAST) begin
                    state_next = ON;
                    pcnt_next  = '0;
                    tick_next  = 4'd0;
                end else begin
                    bcnt_next = bcnt_reg + BW'(1);
                end
            end
            ON: begin
                // tick counts sixteenths across ON and OFF so the slot length
                // stays fixed whatever the brightness.
                if (sub_end) begin
                    pcnt_next = '0;
                    if (tick_reg == bright_reg) begin
                        if (bright_reg == 4'd15) begin
                            slot_end = 1'b1;
                        end else begin
                            state_next = OFF;
                            tick_next  = tick_reg + 4'd1;
                        end
                    end else begin
                        tick_next = tick_reg + 4'd1;
                    end
                end else begin
                    pcnt_next = pcnt_reg + PRESCALE_W'(1);
                end
            end
            OFF: begin
                if (sub_end) begin
                    pcnt_next = '0;
                    if (tick_reg == 4'd15) begin
                        slot_end = 1'b1;
                    end else begin
                        tick_next = tick_reg + 4'd1;
                    end
                end else begin
                    pcnt_next = pcnt_reg + PRESCALE_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (slot_end) begin
            start_slot = 1'b1;
            if (digit_reg == LAST_DIGIT) begin
                frame_done = 1'b1;
                digit_next = 2'd0;
            end else begin
                digit_next = digit_reg + 2'd1;
            end
        end

        // Timing and (on digit 0) the displayed value are latched at slot
        // start so a frame is never torn by mid-scan input changes.
        if (start_slot) begin
            state_next  = BLANK;
            bcnt_next   = '0;
            pre_next    = prescale;
            bright_next = brightness;
            if (digit_next == 2'd0) begin
                snap_next = value;
            end
        end

        if (!enable) begin
            state_next = IDLE;
            digit_next = 2'd0;
            frame_done = 1'b0;
        end

        if (reset) begin
            frame_done = 1'b0;
        end

        // Outputs are computed for the next state so the registered drive
        // lines up with the state register. ON is only entered from BLANK
        // or held, so the current digit and snapshot are already correct.
        if (state_next == ON) begin
            dig_next = onehot[DIGITS-1:0];
            seg_next = lz_mask[digit_reg] ? 7'd0 : dec_seg;
        end
    end

    assign seg_out   = seg_pol ? seg_reg : ~seg_reg;
    assign dig_out   = dig_pol ? dig_reg : ~dig_reg;
    assign cur_digit = digit_reg;

endmodule
